// File: rtl/lag_exit_stats_sink_if.sv
// Exit-link bundle between a router exit port and the per-node stats sink.
// The router drives flits (master); the sink returns one credit per flit (slave).
interface lag_exit_stats_sink_if #(
    parameter int unsigned NPL  = 2,
    parameter int unsigned TS_W = 32
);
    logic [NPL-1:0]      flit_valid;
    logic [NPL-1:0]      flit_tail;
    logic [NPL*TS_W-1:0] flit_ts;
    logic [NPL-1:0]      credit_out;

    modport master (output flit_valid, flit_tail, flit_ts, input credit_out);
    modport slave  (input flit_valid, flit_tail, flit_ts, output credit_out);
endinterface

// File: rtl/lag_exit_stats_sink.sv
// Per-node traffic sink: returns credits, runs warmup/measure/done phases and
// accumulates saturating packet-latency statistics plus a latency histogram.
module lag_exit_stats_sink #(
    parameter int unsigned NPL     = 2,
    parameter int unsigned TS_W    = 32,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned WARMUP  = 100,
    parameter int unsigned MEASURE = 1000,
    parameter int unsigned NBIN    = 101
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lag_exit_stats_sink_if.slave link,
    output logic [1:0]           o_phase,
    output logic                 o_done,
    output logic [CNT_W-1:0]     o_rec_count,
    output logic [CNT_W-1:0]     o_flit_count,
    output logic [CNT_W-1:0]     o_total_latency,
    output logic [TS_W-1:0]      o_min_latency,
    output logic [TS_W-1:0]      o_max_latency,
    output logic [TS_W-1:0]      o_measure_start,
    output logic [TS_W-1:0]      o_measure_end,
    input  logic [6:0]           i_hist_addr,
    output logic [CNT_W-1:0]     o_hist_data
);
    localparam int unsigned PC_W   = $clog2(NPL + 1);
    localparam int unsigned BIN_AW = $clog2(NBIN);
    localparam int unsigned SUM_W  = ((TS_W > CNT_W) ? TS_W : CNT_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TS_W-1:0]  LAT_OVF = TS_W'(NBIN - 1);

    typedef enum logic [1:0] {
        StWarm = 2'd0,
        StMeas = 2'd1,
        StDone = 2'd2
    } phase_e;

    phase_e            r_state, w_state;
    logic [TS_W-1:0]   r_sys_time;
    logic [NPL-1:0]    r_credit;
    logic [CNT_W-1:0]  r_warm_cnt, w_warm_cnt;
    logic [CNT_W-1:0]  r_rec_count, w_rec_count;
    logic [CNT_W-1:0]  r_flit_count, w_flit_count;
    logic [CNT_W-1:0]  r_total, w_total;
    logic [TS_W-1:0]   r_min, w_min;
    logic [TS_W-1:0]   r_max, w_max;
    logic [TS_W-1:0]   r_start, w_start;
    logic [TS_W-1:0]   r_end, w_end;
    logic [CNT_W-1:0]  r_bin [NBIN];
    logic [CNT_W-1:0]  w_bin [NBIN];

    logic [PC_W-1:0]   w_flit_cnt, w_tail_cnt;
    logic [TS_W-1:0]   w_lat;
    logic [BIN_AW-1:0] w_bin_idx;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + b;
        return (s > SUM_W'(CNT_MAX)) ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    always_comb begin
        w_state      = r_state;
        w_warm_cnt   = r_warm_cnt;
        w_rec_count  = r_rec_count;
        w_flit_count = r_flit_count;
        w_total      = r_total;
        w_min        = r_min;
        w_max        = r_max;
        w_start      = r_start;
        w_end        = r_end;
        w_bin        = r_bin;
        w_lat        = '0;
        w_bin_idx    = '0;
        w_flit_cnt   = '0;
        w_tail_cnt   = '0;
        for (int i = 0; i < NPL; i++) begin
            w_flit_cnt = w_flit_cnt + PC_W'(link.flit_valid[i]);
            w_tail_cnt = w_tail_cnt + PC_W'(link.flit_valid[i] & link.flit_tail[i]);
        end

        unique case (r_state)
            StWarm: begin
                // Every tail of the threshold cycle is still warmup traffic.
                w_warm_cnt = sat_add(r_warm_cnt, SUM_W'(w_tail_cnt));
                if (w_warm_cnt >= CNT_W'(WARMUP)) begin
                    w_state = StMeas;
                    w_start = r_sys_time + TS_W'(1);
                end
            end
            StMeas: begin
                w_flit_count = sat_add(r_flit_count, SUM_W'(w_flit_cnt));
                // Ascending link order decides which tails fit under MEASURE.
                for (int i = 0; i < NPL; i++) begin
                    if (link.flit_valid[i] && link.flit_tail[i] &&
                        (w_rec_count < CNT_W'(MEASURE))) begin
                        w_lat       = r_sys_time - link.flit_ts[i*TS_W +: TS_W];
                        w_rec_count = sat_add(w_rec_count, SUM_W'(1));
                        w_total     = sat_add(w_total, SUM_W'(w_lat));
                        if (w_lat < w_min) w_min = w_lat;
                        if (w_lat > w_max) w_max = w_lat;
                        w_bin_idx = (w_lat >= LAT_OVF) ? BIN_AW'(NBIN - 1) : BIN_AW'(w_lat);
                        w_bin[w_bin_idx] = sat_add(w_bin[w_bin_idx], SUM_W'(1));
                    end
                end
                if (w_rec_count >= CNT_W'(MEASURE)) begin
                    w_state = StDone;
                    w_end   = r_sys_time;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StWarm;
            r_sys_time   <= '0;
            r_credit     <= '0;
            r_warm_cnt   <= '0;
            r_rec_count  <= '0;
            r_flit_count <= '0;
            r_total      <= '0;
            r_min        <= '1;
            r_max        <= '0;
            r_start      <= '0;
            r_end        <= '0;
            r_bin        <= '{default: '0};
        end else begin
            r_state      <= w_state;
            r_sys_time   <= r_sys_time + TS_W'(1);
            r_credit     <= link.flit_valid;
            r_warm_cnt   <= w_warm_cnt;
            r_rec_count  <= w_rec_count;
            r_flit_count <= w_flit_count;
            r_total      <= w_total;
            r_min        <= w_min;
            r_max        <= w_max;
            r_start      <= w_start;
            r_end        <= w_end;
            r_bin        <= w_bin;
        end
    end

    assign link.credit_out   = r_credit;
    assign o_phase           = r_state;
    assign o_done            = (r_state == StDone);
    assign o_rec_count       = r_rec_count;
    assign o_flit_count      = r_flit_count;
    assign o_total_latency   = r_total;
    assign o_min_latency     = r_min;
    assign o_max_latency     = r_max;
    assign o_measure_start   = r_start;
    assign o_measure_end     = r_end;
    assign o_hist_data       = (32'(i_hist_addr) < NBIN) ? r_bin[BIN_AW'(i_hist_addr)] : '0;

endmodule
